// File: rtl/ram_pkg.sv
// Shared types and helpers for the byte-enable dual-port RAM and its clear engine.
package ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic int lane_count(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_clear_ctrl.sv
// Clear engine: walks every address once writing zero, then reports the array ready.
module ram_clear_ctrl
    import ram_pkg::*;
#(
    parameter int ADDR_WIDTH     = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_clear,
    output logic                  o_ready,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  ready_q;
    logic                  clr_we_q;

    // Counter wraps back to zero after the last address, ready for the next clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
            if (CLEAR_ON_RESET != 0) begin
                state_q  <= ST_CLEAR;
                ready_q  <= 1'b0;
                clr_we_q <= 1'b1;
            end else begin
                state_q  <= ST_IDLE;
                ready_q  <= 1'b1;
                clr_we_q <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_clear) begin
                        state_q  <= ST_CLEAR;
                        cnt_q    <= '0;
                        ready_q  <= 1'b0;
                        clr_we_q <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        state_q  <= ST_IDLE;
                        ready_q  <= 1'b1;
                        clr_we_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= '0;
                    ready_q  <= 1'b1;
                    clr_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready    = ready_q;
    assign o_clr_we   = clr_we_q;
    assign o_clr_addr = cnt_q;

endmodule

// File: rtl/ram_dp_be.sv
// Simple-dual-port RAM with byte-lane write enables, registered reads with valid,
// selectable read-during-write behaviour and a hardware clear engine.
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 4,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clear,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [ADDR_WIDTH-1:0]   i_waddr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic                    i_re,
    input  logic [ADDR_WIDTH-1:0]   i_raddr,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic                    o_rd_valid,
    output logic                    o_ready
);

    localparam int LANES = lane_count(DATA_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    generate
        if ((DATA_WIDTH % 8) != 0 || DATA_WIDTH == 0) begin : g_bad_width
            $error("ram_dp_be: DATA_WIDTH must be a non-zero multiple of 8");
        end
        if (RDW_MODE != RDW_OLD && RDW_MODE != RDW_NEW) begin : g_bad_rdw
            $error("ram_dp_be: RDW_MODE must be 0 (old data) or 1 (new data)");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  ready;
    logic                  clr_we;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_word_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rd_valid_q;

    ram_clear_ctrl #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear_ctrl (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (i_clear),
        .o_ready    (ready),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr)
    );

    // Clear and reset both take precedence over user traffic in the same cycle.
    assign wr_acc = ready & ~i_clear & ~i_rst & i_we;
    assign rd_acc = ready & ~i_clear & ~i_rst & i_re;

    always_ff @(posedge i_clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (wr_acc) begin
            for (int k = 0; k < LANES; k++) begin
                if (i_be[k]) begin
                    mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

    // Same-address bypass forwards only the lanes being written this cycle.
    always_comb begin
        rd_word_d = mem[i_raddr];
        if (RDW_MODE == RDW_NEW && wr_acc && (i_waddr == i_raddr)) begin
            for (int k = 0; k < LANES; k++) begin
                if (i_be[k]) begin
                    rd_word_d[8*k +: 8] = i_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (rd_acc) begin
                rdata_q <= rd_word_d;
            end
        end
    end

    assign o_rdata    = rdata_q;
    assign o_rd_valid = rd_valid_q;
    assign o_ready    = ready;

endmodule

// File: tb/tb_ram_dp_be.sv
// Scoreboard bench: two instances (old-data and new-data read-during-write) share stimulus.
module tb_ram_dp_be;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, clear, we, re;
    logic [3:0]  be, waddr, raddr;
    logic [31:0] wdata;
    logic [31:0] rdata0, rdata1;
    logic        vld0, vld1, rdy0, rdy1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_we(we), .i_be(be),
        .i_waddr(waddr), .i_wdata(wdata), .i_re(re), .i_raddr(raddr),
        .o_rdata(rdata0), .o_rd_valid(vld0), .o_ready(rdy0)
    );

    ram_dp_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_we(we), .i_be(be),
        .i_waddr(waddr), .i_wdata(wdata), .i_re(re), .i_raddr(raddr),
        .o_rdata(rdata1), .o_rd_valid(vld1), .o_ready(rdy1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, act, exp);
        end
    endtask

    task automatic mon_one(input int sel);
        exp_t        e;
        logic        v;
        logic [31:0] d;
        int          n;
        v = (sel == 0) ? vld0 : vld1;
        d = (sel == 0) ? rdata0 : rdata1;
        n = (sel == 0) ? q0.size() : q1.size();
        if (n > 0) begin
            e = (sel == 0) ? q0[0] : q1[0];
            if (e.cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_missing mode%0d at cyc %0d got none required %h", sel, cyc, e.data);
                if (sel == 0) e = q0.pop_front(); else e = q1.pop_front();
            end
        end
        if (v) begin
            checks++;
            n = (sel == 0) ? q0.size() : q1.size();
            if (n == 0) begin
                errors++;
                $display("FAIL unexpected_rd_valid mode%0d at cyc %0d got %h required no valid", sel, cyc, d);
            end else begin
                if (sel == 0) e = q0.pop_front(); else e = q1.pop_front();
                if (d !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL rdata mode%0d got %h at cyc %0d required %h at cyc %0d",
                             sel, d, cyc, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            mon_one(0);
            mon_one(1);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] e0, input logic [31:0] e1);
        q0.push_back('{data: e0, cyc: cyc + 1});
        q1.push_back('{data: e1, cyc: cyc + 1});
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        we = 1'b1; waddr = a; wdata = d; be = b;
        step();
        we = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e0, input logic [31:0] e1);
        re = 1'b1; raddr = a;
        push(e0, e1);
        step();
        re = 1'b0;
    endtask

    task automatic rw(input logic [3:0] wa, input logic [31:0] d, input logic [3:0] b,
                      input logic [3:0] ra, input logic [31:0] e0, input logic [31:0] e1);
        we = 1'b1; waddr = wa; wdata = d; be = b;
        re = 1'b1; raddr = ra;
        push(e0, e1);
        step();
        we = 1'b0; re = 1'b0;
    endtask

    task automatic wait_ready(input string nm, input int exp_n);
        int n = 0;
        while (!(rdy0 && rdy1) && n < 40) begin
            step();
            n++;
        end
        chk(nm, n, exp_n);
    endtask

    initial begin
        logic [31:0] e0, e1;
        rst = 1'b1; clear = 1'b0; we = 1'b0; re = 1'b0;
        be = '0; waddr = '0; raddr = '0; wdata = '0;
        fork
            monitor_loop();
        join_none

        // Reset and power-on clear
        step();
        rst = 1'b0;
        chk("reset_ready0", {31'd0, rdy0}, 32'd0);
        chk("reset_ready1", {31'd0, rdy1}, 32'd0);
        chk("reset_valid", {31'd0, vld0}, 32'd0);
        chk("reset_rdata", rdata0, 32'd0);
        wait_ready("reset_clear_cycles", 16);
        for (int a = 0; a < DEPTH; a++) rd(4'(a), 32'h0, 32'h0);
        step();

        // Byte enables and zero-enable no-op
        wr(4'd3, 32'hAABBCCDD, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd(4'd3, 32'hAA22CC44, 32'hAA22CC44);
        wr(4'd3, 32'h99999999, 4'b0000);
        rd(4'd3, 32'hAA22CC44, 32'hAA22CC44);

        // Read-during-write, same address and different address
        wr(4'd5, 32'h12345678, 4'b1111);
        rw(4'd5, 32'hFFFFFFFF, 4'b0011, 4'd5, 32'h12345678, 32'h1234FFFF);
        rd(4'd5, 32'h1234FFFF, 32'h1234FFFF);
        rw(4'd6, 32'h0BADF00D, 4'b1111, 4'd5, 32'h1234FFFF, 32'h1234FFFF);
        rd(4'd6, 32'h0BADF00D, 32'h0BADF00D);
        step(); step();

        // Runtime clear colliding with a write and a read
        wr(4'd2, 32'd8, 4'b1111);
        wr(4'd3, 32'd10, 4'b1111);
        wr(4'd4, 32'd15, 4'b1111);
        rd(4'd2, 32'd8, 32'd8);
        rd(4'd4, 32'd15, 32'd15);
        step(); step();
        clear = 1'b1; we = 1'b1; waddr = 4'd2; wdata = 32'hDEADBEEF; be = 4'hF;
        re = 1'b1; raddr = 4'd2;
        step();
        clear = 1'b0;
        chk("clear_ready_low", {31'd0, rdy0}, 32'd0);
        waddr = 4'd7; wdata = 32'h55555555; raddr = 4'd3;
        wait_ready("runtime_clear_cycles", 16);
        we = 1'b0; re = 1'b0;
        for (int a = 0; a < DEPTH; a++) rd(4'(a), 32'h0, 32'h0);
        step();

        // Reset during a read, then reset again mid-clear
        wr(4'd9, 32'hCAFEBABE, 4'b1111);
        rd(4'd9, 32'hCAFEBABE, 32'hCAFEBABE);
        step(); step();
        rst = 1'b1; re = 1'b1; raddr = 4'd9;
        step();
        rst = 1'b0; re = 1'b0;
        chk("rst_read_valid", {31'd0, vld0}, 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_ready_low", {31'd0, rdy1}, 32'd0);
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready("reset_midclear_cycles", 16);
        rd(4'd9, 32'h0, 32'h0);

        // Random stress: writes every 5 cycles, continuous reads
        for (int a = 0; a < DEPTH; a++) model[a] = 32'h0;
        for (int i = 0; i < 1000; i++) begin
            re = 1'b1;
            raddr = 4'($urandom_range(2, 4));
            we = ((i % 5) == 0);
            if (we) begin
                waddr = 4'($urandom_range(2, 4));
                wdata = $urandom_range(8, 15);
                be = 4'($urandom_range(0, 15));
            end
            e0 = model[raddr];
            e1 = e0;
            if (we && waddr == raddr) begin
                for (int k = 0; k < 4; k++) if (be[k]) e1[8*k +: 8] = wdata[8*k +: 8];
            end
            push(e0, e1);
            step();
            if (we) begin
                for (int k = 0; k < 4; k++) if (be[k]) model[waddr][8*k +: 8] = wdata[8*k +: 8];
            end
        end
        we = 1'b0; re = 1'b0;
        step(); step(); step();
        chk("scoreboard_drained", 32'(q0.size() + q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
